// File: rtl/sdram_port_sched_if.sv
// Command handshake between the SDRAM burst scheduler (master) and the SDRAM
// command/refresh engine (slave).
interface sdram_port_sched_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              cmd_req;
  logic              cmd_ack;
  logic              cmd_done;
  logic [1:0]        cmd_port;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [8:0]        cmd_len;

  modport master (
    output cmd_req, cmd_port, cmd_wr, cmd_addr, cmd_len,
    input  cmd_ack, cmd_done
  );

  modport slave (
    input  cmd_req, cmd_port, cmd_wr, cmd_addr, cmd_len,
    output cmd_ack, cmd_done
  );
endinterface

// File: rtl/sdram_port_sched.sv
// Burst scheduler for the 4-port SDRAM frame buffer (WR1, WR2, RD1, RD2).
// Define SCHED_RR_EN for round-robin arbitration; default is fixed priority RD2 > WR1 > WR2 > RD1.
module sdram_port_sched #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned USE_W      = 10,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned WR_LEN     = 256,
  parameter int unsigned RD_LEN     = 128,
  parameter int unsigned P0_BASE    = 0,
  parameter int unsigned P0_MAX     = 307200,
  parameter int unsigned P1_BASE    = 307200,
  parameter int unsigned P1_MAX     = 614400,
  parameter int unsigned P2_BASE    = 0,
  parameter int unsigned P2_MAX     = 307200,
  parameter int unsigned P3_BASE    = 307200,
  parameter int unsigned P3_MAX     = 614400
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_done,
  input  logic [2*USE_W-1:0]   wr_use,
  input  logic [2*USE_W-1:0]   rd_use,
  input  logic [3:0]           load,
  sdram_port_sched_if.master   eng,
  output logic                 busy
);

  localparam int unsigned LEN_W   = 9;
  localparam int unsigned NPORT   = 4;
  localparam int unsigned RD_ROOM = FIFO_DEPTH - RD_LEN;

  typedef enum logic [1:0] {
    S_WAIT_INIT = 2'd0,
    S_ARB       = 2'd1,
    S_ISSUE     = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               cmd_req_q, cmd_req_d;
  logic [1:0]         port_q, port_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               busy_q, busy_d;
  logic               ld_hit_q, ld_hit_d;
  logic [ADDR_W-1:0]  ptr_q [NPORT];
  logic [ADDR_W-1:0]  ptr_d [NPORT];

  logic [NPORT-1:0]   elig_c;
  logic [1:0]         grant_c;
  logic [ADDR_W-1:0]  ptr_sum_c;
  logic [ADDR_W-1:0]  ptr_next_c;
  logic               burst_end_c;

  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] p);
    case (p)
      2'd0:    base_of = ADDR_W'(P0_BASE);
      2'd1:    base_of = ADDR_W'(P1_BASE);
      2'd2:    base_of = ADDR_W'(P2_BASE);
      default: base_of = ADDR_W'(P3_BASE);
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] max_of(input logic [1:0] p);
    case (p)
      2'd0:    max_of = ADDR_W'(P0_MAX);
      2'd1:    max_of = ADDR_W'(P1_MAX);
      2'd2:    max_of = ADDR_W'(P2_MAX);
      default: max_of = ADDR_W'(P3_MAX);
    endcase
  endfunction

  // Writers need a full burst queued; readers need room for a full burst.
  assign elig_c[0] = wr_use[USE_W-1:0]       >= USE_W'(WR_LEN);
  assign elig_c[1] = wr_use[2*USE_W-1:USE_W] >= USE_W'(WR_LEN);
  assign elig_c[2] = rd_use[USE_W-1:0]       <= USE_W'(RD_ROOM);
  assign elig_c[3] = rd_use[2*USE_W-1:USE_W] <= USE_W'(RD_ROOM);

`ifdef SCHED_RR_EN
  logic [1:0] last_q, last_d;

  // Closest eligible port after the last grant wins; scan far-to-near so the nearest overrides.
  always_comb begin : rr_pick
    logic [1:0] idx;
    grant_c = last_q;
    idx     = last_q;
    for (int k = NPORT; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (elig_c[idx]) grant_c = idx;
    end
  end
`else
  // Display underrun is the visible failure, so RD2 is served first.
  always_comb begin
    if (elig_c[3])      grant_c = 2'd3;
    else if (elig_c[0]) grant_c = 2'd0;
    else if (elig_c[1]) grant_c = 2'd1;
    else                grant_c = 2'd2;
  end
`endif

  // Windows are far below 2^ADDR_W, so the sum cannot overflow before the compare.
  assign ptr_sum_c  = ptr_q[port_q] + ADDR_W'(len_q);
  assign ptr_next_c = (ptr_sum_c >= max_of(port_q)) ? base_of(port_q) : ptr_sum_c;

  always_comb begin
    state_d     = state_q;
    cmd_req_d   = cmd_req_q;
    port_d      = port_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    len_d       = len_q;
    ld_hit_d    = ld_hit_q;
    burst_end_c = 1'b0;
`ifdef SCHED_RR_EN
    last_d      = last_q;
`endif
    for (int i = 0; i < NPORT; i++) begin
      ptr_d[i] = load[i] ? base_of(2'(i)) : ptr_q[i];
    end

    if (!init_done) begin
      state_d   = S_WAIT_INIT;
      cmd_req_d = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_INIT: state_d = S_ARB;
        S_ARB: begin
          if (|elig_c) begin
            port_d    = grant_c;
            wr_d      = ~grant_c[1];
            addr_d    = ptr_d[grant_c];
            len_d     = grant_c[1] ? LEN_W'(RD_LEN) : LEN_W'(WR_LEN);
            cmd_req_d = 1'b1;
            ld_hit_d  = 1'b0;
            state_d   = S_ISSUE;
`ifdef SCHED_RR_EN
            last_d    = grant_c;
`endif
          end
        end
        S_ISSUE: begin
          if (load[port_q]) ld_hit_d = 1'b1;
          if (eng.cmd_ack) begin
            cmd_req_d   = 1'b0;
            state_d     = S_WAIT_DONE;
            burst_end_c = eng.cmd_done;
          end
        end
        S_WAIT_DONE: begin
          if (load[port_q]) ld_hit_d = 1'b1;
          burst_end_c = eng.cmd_done;
        end
        default: state_d = S_WAIT_INIT;
      endcase

      // A reload seen at any point of the burst suppresses its pointer advance.
      if (burst_end_c) begin
        state_d = S_ARB;
        if (!ld_hit_q && !load[port_q]) ptr_d[port_q] = ptr_next_c;
      end
    end

    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_WAIT_INIT;
      cmd_req_q <= 1'b0;
      port_q    <= 2'd0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      busy_q    <= 1'b0;
      ld_hit_q  <= 1'b0;
      for (int i = 0; i < NPORT; i++) ptr_q[i] <= base_of(2'(i));
    end else begin
      state_q   <= state_d;
      cmd_req_q <= cmd_req_d;
      port_q    <= port_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      busy_q    <= busy_d;
      ld_hit_q  <= ld_hit_d;
      for (int i = 0; i < NPORT; i++) ptr_q[i] <= ptr_d[i];
    end
  end

`ifdef SCHED_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 2'd3;
    else        last_q <= last_d;
  end
`endif

  assign eng.cmd_req  = cmd_req_q;
  assign eng.cmd_port = port_q;
  assign eng.cmd_wr   = wr_q;
  assign eng.cmd_addr = addr_q;
  assign eng.cmd_len  = len_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sdram_port_sched.sv
// Bench for sdram_port_sched: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the scheduler.
module tb_sdram_port_sched;

  localparam int unsigned ADDR_W = 24;
  localparam logic [19:0] ALL_WR  = {10'd256, 10'd256};
  localparam logic [19:0] ALL_RD  = {10'd0,   10'd0};
  localparam logic [19:0] WR1_ONLY = {10'd0,  10'd256};
  localparam logic [19:0] NO_WR   = {10'd0,   10'd0};
  localparam logic [19:0] NO_RD   = {10'd512, 10'd512};
  localparam logic [19:0] RD2_ONLY = {10'd0,  10'd512};
`ifdef SCHED_RR_EN
  localparam int FIRST_PORT = 0;
  localparam int FIRST_ADDR = 0;
`else
  localparam int FIRST_PORT = 3;
  localparam int FIRST_ADDR = 307200;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done = 1'b0;
  logic [19:0] wr_t = ALL_WR, rd_t = ALL_RD, wr_r = ALL_WR, rd_r = ALL_RD;
  logic [3:0]  load_t = 4'd0, load_r = 4'd0;
  logic ack_t = 1'b0, done_t = 1'b0, ack_r = 1'b0, done_r = 1'b0;
  logic rnd_on = 1'b0;
  bit   r_out = 1'b0;
  logic [19:0] wr_use, rd_use;
  logic [3:0]  load;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;

  sdram_port_sched_if #(.ADDR_W(ADDR_W)) eng ();

  assign wr_use       = rnd_on ? wr_r : wr_t;
  assign rd_use       = rnd_on ? rd_r : rd_t;
  assign load         = load_t | load_r;
  assign eng.cmd_ack  = ack_t | ack_r;
  assign eng.cmd_done = done_t | done_r;

  sdram_port_sched dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .wr_use(wr_use), .rd_use(rd_use), .load(load),
    .eng(eng), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int base_of(input int p);
    return (p == 1 || p == 3) ? 307200 : 0;
  endfunction

  function automatic int max_of(input int p);
    return (p == 1 || p == 3) ? 614400 : 307200;
  endfunction

  // Reference model: one outstanding burst at a time, described as a transaction.
  int  m_ptr [4];
  bit  m_can_arb, m_fly, m_acked, m_reloaded, m_req;
  int  m_port, m_last, m_addr, m_len;

  function automatic int pick(input logic [3:0] e, input int last);
`ifdef SCHED_RR_EN
    for (int k = 1; k <= 4; k++) if (e[(last + k) % 4]) return (last + k) % 4;
`else
    if (e[3]) return 3;
    if (e[0]) return 0;
    if (e[1]) return 1;
    if (e[2]) return 2;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ptr[i] = base_of(i);
    m_can_arb = 0; m_fly = 0; m_acked = 0; m_reloaded = 0; m_req = 0;
    m_port = 0; m_last = 3; m_addr = 0; m_len = 0;
  endtask

  // Advance the model by the clock edge that will sample the inputs present now.
  task automatic model_step();
    logic [3:0] e;
    int g, nxt;
    for (int i = 0; i < 4; i++) if (load[i]) m_ptr[i] = base_of(i);
    if (!init_done) begin
      m_can_arb = 0; m_fly = 0; m_req = 0;
    end else if (m_fly) begin
      if (load[m_port]) m_reloaded = 1;
      if (!m_acked && eng.cmd_ack) begin m_acked = 1; m_req = 0; end
      if (m_acked && eng.cmd_done) begin
        if (!m_reloaded) begin
          nxt = m_ptr[m_port] + m_len;
          m_ptr[m_port] = (nxt >= max_of(m_port)) ? base_of(m_port) : nxt;
        end
        m_fly = 0; m_can_arb = 1;
      end
    end else if (m_can_arb) begin
      e[0] = int'(wr_use[9:0])   >= 256;
      e[1] = int'(wr_use[19:10]) >= 256;
      e[2] = int'(rd_use[9:0])   <= 512 - 128;
      e[3] = int'(rd_use[19:10]) <= 512 - 128;
      g = pick(e, m_last);
      if (g >= 0) begin
        m_port = g; m_last = g; m_addr = m_ptr[g]; m_len = (g < 2) ? 256 : 128;
        m_fly = 1; m_acked = 0; m_req = 1; m_reloaded = 0; m_can_arb = 0;
      end
    end else begin
      m_can_arb = 1;
    end
  endtask

  // Single compare process: DUT outputs against the model, every cycle out of reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      chk("cmd_req",  32'(eng.cmd_req),  32'(m_req));
      chk("busy",     32'(busy),         32'(m_fly));
      chk("cmd_port", 32'(eng.cmd_port), 32'(m_port));
      chk("cmd_wr",   32'(eng.cmd_wr),   32'(m_len == 256));
      chk("cmd_addr", 32'(eng.cmd_addr), 32'(m_addr));
      chk("cmd_len",  32'(eng.cmd_len),  32'(m_len));
      model_step();
    end
  end

  // Randomized engine and FIFO levels, active only during the random phase.
  always @(posedge clk) begin
    #1;
    ack_r = 1'b0; done_r = 1'b0; load_r = 4'd0;
    if (rnd_on) begin
      wr_r = {10'($urandom_range(0, 511)), 10'($urandom_range(0, 511))};
      rd_r = {10'($urandom_range(0, 512)), 10'($urandom_range(0, 512))};
      for (int i = 0; i < 4; i++) load_r[i] = ($urandom_range(0, 40) == 0);
      if (!init_done) r_out = 1'b0;
      else if (r_out) begin
        if ($urandom_range(0, 3) == 0) begin done_r = 1'b1; r_out = 1'b0; end
      end else if (eng.cmd_req && $urandom_range(0, 2) == 0) begin
        ack_r = 1'b1;
        if ($urandom_range(0, 3) == 0) done_r = 1'b1;
        else r_out = 1'b1;
      end
    end
  end

  // Act as the command engine for one burst; new levels/reloads are applied with done.
  task automatic serve(input int ack_d, input int done_d, input logic [3:0] ld,
                       input logic [19:0] nwr, input logic [19:0] nrd,
                       output int p, output int a, output int w, output int l);
    int n;
    n = 0;
    while (!eng.cmd_req && n < 64) begin @(posedge clk); #1; n++; end
    chk("req_seen", 32'(eng.cmd_req), 32'd1);
    p = int'(eng.cmd_port); a = int'(eng.cmd_addr);
    w = int'(eng.cmd_wr);   l = int'(eng.cmd_len);
    repeat (ack_d) begin
      @(posedge clk); #1;
      chk("hold_req",  32'(eng.cmd_req),  32'd1);
      chk("hold_port", 32'(eng.cmd_port), 32'(p));
      chk("hold_addr", 32'(eng.cmd_addr), 32'(a));
    end
    ack_t = 1'b1;
    if (done_d == 0) begin done_t = 1'b1; load_t = ld; wr_t = nwr; rd_t = nrd; end
    @(posedge clk); #1;
    ack_t = 1'b0; done_t = 1'b0; load_t = 4'd0;
    chk("req_drop", 32'(eng.cmd_req), 32'd0);
    if (done_d > 0) begin
      repeat (done_d - 1) begin @(posedge clk); #1; end
      done_t = 1'b1; load_t = ld; wr_t = nwr; rd_t = nrd;
      @(posedge clk); #1;
      done_t = 1'b0; load_t = 4'd0;
    end
  endtask

  initial begin
    int p, a, w, l;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_req",  32'(eng.cmd_req),  32'd0);
    chk("rst_busy", 32'(busy),         32'd0);
    chk("rst_addr", 32'(eng.cmd_addr), 32'd0);
    chk("rst_len",  32'(eng.cmd_len),  32'd0);

    // Everything eligible but SDRAM not initialised: no request may appear.
    repeat (5) begin @(posedge clk); #1; chk("req_pre_init", 32'(eng.cmd_req), 32'd0); end
    init_done = 1'b1;
    @(posedge clk); #1; chk("req_init_p1", 32'(eng.cmd_req), 32'd0);
    @(posedge clk); #1; chk("req_init_p2", 32'(eng.cmd_req), 32'd1);
    chk("first_port", 32'(eng.cmd_port), 32'(FIRST_PORT));
    serve(1, 2, 4'hF, WR1_ONLY, NO_RD, p, a, w, l);
    chk("first_addr", 32'(a), 32'(FIRST_ADDR));

    // Only WR1 eligible; all pointers were reloaded together with the previous done.
    serve(0, 3, 4'h0, WR1_ONLY, NO_RD, p, a, w, l);
    chk("wr1_port", 32'(p), 32'd0);
    chk("wr1_wr",   32'(w), 32'd1);
    chk("wr1_addr", 32'(a), 32'd0);
    chk("wr1_len",  32'(l), 32'd256);
    for (int k = 1; k <= 1200; k++) begin
      serve(0, 0, 4'h0, WR1_ONLY, NO_RD, p, a, w, l);
      chk("wr1_run_addr", 32'(a), 32'((k < 1200) ? 256 * k : 0));
    end

    // Slow ack: request and payload hold for the whole wait.
    serve(7, 2, 4'h0, NO_WR, RD2_ONLY, p, a, w, l);
    chk("slow_ack_addr", 32'(a), 32'd256);

    serve(2, 1, 4'h0, NO_WR, RD2_ONLY, p, a, w, l);
    chk("rd2_port", 32'(p), 32'd3);
    chk("rd2_addr", 32'(a), 32'd307200);
    chk("rd2_len",  32'(l), 32'd128);
    serve(1, 0, 4'b1000, NO_WR, RD2_ONLY, p, a, w, l);
    chk("rd2_addr2", 32'(a), 32'd307328);
    serve(0, 1, 4'h0, NO_WR, NO_RD, p, a, w, l);
    chk("rd2_reload_addr", 32'(a), 32'd307200);

`ifdef SCHED_RR_EN
    wr_t = ALL_WR; rd_t = ALL_RD;
    for (int i = 0; i < 5; i++) begin
      serve(0, 1, 4'h0, ALL_WR, ALL_RD, p, a, w, l);
      chk("rr_order", 32'(p), 32'(i % 4));
    end
`endif

    rnd_on = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (init_done && $urandom_range(0, 299) == 0) init_done = 1'b0;
      else if (!init_done && $urandom_range(0, 2) == 0) init_done = 1'b1;
    end
    rnd_on = 1'b0;
    init_done = 1'b1;
    repeat (10) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
